// File: rtl/trig_lookup_arbiter.sv
// Round-robin arbiter sharing one cos/sin ROM pair among NUM_REQ requesters, with tagged responses.
// Optional grant/stall statistics counters are enabled by defining TRIG_ARB_STATS_EN.
module trig_lookup_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ANGLE_W     = 9,
    parameter int unsigned DATA_W      = 11,
    parameter int unsigned ROM_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ANGLE_W-1:0]   req_angle,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [ANGLE_W-1:0]           rom_addr,
    input  logic [DATA_W-1:0]            rom_cos,
    input  logic [DATA_W-1:0]            rom_sin,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_cos,
    output logic [DATA_W-1:0]            rsp_sin,
    output logic                         busy
`ifdef TRIG_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]        grant_cnt,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DEPTH = ROM_LATENCY + 1;
    localparam logic [ANGLE_W-1:0] FULL_TURN = ANGLE_W'(360);

    logic [ANGLE_W-1:0] angle_arr [NUM_REQ];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_c;
    logic [ANGLE_W-1:0] angle_sel_c;
    logic [PTR_W-1:0]   idx_c;
    logic [ANGLE_W-1:0] rom_addr_q, rom_addr_d;
    logic [NUM_REQ-1:0] tag_q [DEPTH];
    logic [NUM_REQ-1:0] tag_d [DEPTH];
    logic [DATA_W-1:0]  rsp_cos_q, rsp_cos_d;
    logic [DATA_W-1:0]  rsp_sin_q, rsp_sin_d;
    logic               busy_q, busy_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign angle_arr[g] = req_angle[g*ANGLE_W +: ANGLE_W];
    end

    // Round-robin search starting at the pointer; first valid requester wins.
    always_comb begin
        grant_c     = '0;
        angle_sel_c = '0;
        ptr_d       = ptr_q;
        idx_c       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx_c = PTR_W'((32'(ptr_q) + off) % NUM_REQ);
            if ((grant_c == '0) && req_valid[idx_c]) begin
                grant_c[idx_c] = 1'b1;
                angle_sel_c    = angle_arr[idx_c];
                ptr_d          = PTR_W'((32'(idx_c) + 1) % NUM_REQ);
            end
        end
    end

    // Issue path, tag pipeline and response capture.
    always_comb begin
        rom_addr_d = rom_addr_q;
        rsp_cos_d  = rsp_cos_q;
        rsp_sin_d  = rsp_sin_q;
        busy_d     = 1'b0;
        if (grant_c != '0) begin
            rom_addr_d = (angle_sel_c >= FULL_TURN) ? angle_sel_c - FULL_TURN : angle_sel_c;
        end
        tag_d[0] = grant_c;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            busy_d = busy_d | (|tag_d[k]);
        end
        // ROM data lines up with the stage just before the response output.
        if (|tag_q[DEPTH-2]) begin
            rsp_cos_d = rom_cos;
            rsp_sin_d = rom_sin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            rsp_cos_q  <= '0;
            rsp_sin_q  <= '0;
            busy_q     <= 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            rsp_cos_q  <= rsp_cos_d;
            rsp_sin_q  <= rsp_sin_d;
            busy_q     <= busy_d;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign req_ready = grant_c;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = tag_q[DEPTH-1];
    assign rsp_cos   = rsp_cos_q;
    assign rsp_sin   = rsp_sin_q;
    assign busy      = busy_q;

`ifdef TRIG_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] stall_cnt_q;

    // Saturating counters; a stall is any valid requester left ungranted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            if (((req_valid & ~grant_c) != '0) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_c[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack_cnt
        assign grant_cnt[g*16 +: 16] = grant_cnt_q[g];
    end
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
// Directed bench for trig_lookup_arbiter with a 1-register ROM model (cos=3a+7, sin=5a+1).
module tb_trig_lookup_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ANGLE_W = 9;
    localparam int unsigned DATA_W  = 11;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ANGLE_W-1:0] req_angle;
    logic [NUM_REQ-1:0]         req_ready;
    logic [ANGLE_W-1:0]         rom_addr;
    logic [DATA_W-1:0]          rom_cos;
    logic [DATA_W-1:0]          rom_sin;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [DATA_W-1:0]          rsp_cos;
    logic [DATA_W-1:0]          rsp_sin;
    logic                       busy;
`ifdef TRIG_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]      grant_cnt;
    logic [15:0]                stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    trig_lookup_arbiter #(
        .NUM_REQ(NUM_REQ), .ANGLE_W(ANGLE_W), .DATA_W(DATA_W), .ROM_LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .rom_addr(rom_addr), .rom_cos(rom_cos), .rom_sin(rom_sin),
        .rsp_valid(rsp_valid), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
        .busy(busy)
`ifdef TRIG_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_cos <= DATA_W'(32'(rom_addr) * 3 + 7);
        rom_sin <= DATA_W'(32'(rom_addr) * 5 + 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] alt_grant(input int k);
        if (k < 0 || k >= 6) return 2'b00;
        return (k % 2 == 0) ? 2'b10 : 2'b01;
    endfunction

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_angle = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(req_ready), 0);
        check("reset_addr", 32'(rom_addr), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_cos", 32'(rsp_cos), 0);
        check("reset_rsp_sin", 32'(rsp_sin), 0);
        check("reset_busy", 32'(busy), 0);

        // Single lookup of 90 degrees from requester 0.
        @(negedge clk); req_valid = 2'b01; req_angle = {9'd0, 9'd90}; #1;
        check("single_ready", 32'(req_ready), 1);
        @(negedge clk); req_valid = 2'b00; #1;
        check("single_addr", 32'(rom_addr), 90);
        check("single_busy1", 32'(busy), 1);
        @(negedge clk); #1;
        check("single_rsp_c2", 32'(rsp_valid), 0);
        @(negedge clk); #1;
        check("single_rsp_valid", 32'(rsp_valid), 1);
        check("single_rsp_cos", 32'(rsp_cos), 277);
        check("single_rsp_sin", 32'(rsp_sin), 451);
        check("single_busy3", 32'(busy), 1);
        @(negedge clk); #1;
        check("single_rsp_c4", 32'(rsp_valid), 0);
        check("single_busy4", 32'(busy), 0);

        // Pointer now at 1: both valid -> 10,01,10,... with no bubbles.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid = (k < 6) ? 2'b11 : 2'b00;
            req_angle = {9'd180, 9'd0};
            #1;
            check($sformatf("alt_ready_%0d", k), 32'(req_ready), 32'(alt_grant(k)));
            if (k >= 1 && k <= 6)
                check($sformatf("alt_addr_%0d", k), 32'(rom_addr), (alt_grant(k-1) == 2'b10) ? 180 : 0);
            if (k >= 3) begin
                check($sformatf("alt_rsp_%0d", k), 32'(rsp_valid), 32'(alt_grant(k-3)));
                if (alt_grant(k-3) != 2'b00)
                    check($sformatf("alt_cos_%0d", k), 32'(rsp_cos), (alt_grant(k-3) == 2'b10) ? 547 : 7);
            end
            if (k >= 1)
                check($sformatf("alt_busy_%0d", k), 32'(busy), (k <= 8) ? 1 : 0);
        end

        // Angle normalisation: 360 -> 0, 511 -> 151; requester 0 re-requests back to back.
        @(negedge clk); req_valid = 2'b01; req_angle = {9'd0, 9'd360}; #1;
        check("norm_ready0", 32'(req_ready), 1);
        @(negedge clk); req_angle = {9'd0, 9'd511}; #1;
        check("norm_ready1", 32'(req_ready), 1);
        check("norm_addr360", 32'(rom_addr), 0);
        @(negedge clk); req_valid = 2'b00; #1;
        check("norm_addr511", 32'(rom_addr), 151);
        @(negedge clk); #1;
        check("norm_rsp0_valid", 32'(rsp_valid), 1);
        check("norm_rsp0_cos", 32'(rsp_cos), 7);
        check("norm_rsp0_sin", 32'(rsp_sin), 1);
        @(negedge clk); #1;
        check("norm_rsp1_valid", 32'(rsp_valid), 1);
        check("norm_rsp1_cos", 32'(rsp_cos), 460);
        check("norm_rsp1_sin", 32'(rsp_sin), 756);
        @(negedge clk); #1;
        check("norm_idle_busy", 32'(busy), 0);

        // Reset one cycle after a grant discards the in-flight lookup.
        @(negedge clk); req_valid = 2'b10; req_angle = {9'd45, 9'd0}; #1;
        check("rst_pre_ready", 32'(req_ready), 2);
        @(negedge clk); req_valid = 2'b00; rst = 1'b1; #1;
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_cos", 32'(rsp_cos), 0);
        check("rst_rsp_sin", 32'(rsp_sin), 0);
        check("rst_ready", 32'(req_ready), 0);
        @(negedge clk); rst = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check($sformatf("rst_no_rsp_%0d", k), 32'(rsp_valid), 0);
        end

        // Pointer back at 0 after reset; then a short grant pattern for the counters.
        @(negedge clk); req_valid = 2'b11; req_angle = {9'd10, 9'd20}; #1;
        check("post_rst_ready", 32'(req_ready), 1);
        @(negedge clk); req_valid = 2'b10; #1;
        check("post_rst_ready_r1", 32'(req_ready), 2);
        @(negedge clk); req_valid = 2'b01; #1;
        check("post_rst_ready_c", 32'(req_ready), 1);
        @(negedge clk); #1;
        check("post_rst_ready_d", 32'(req_ready), 1);
        @(negedge clk); req_valid = 2'b00; #1;
`ifdef TRIG_ARB_STATS_EN
        check("stats_grant0", 32'(grant_cnt[15:0]), 3);
        check("stats_grant1", 32'(grant_cnt[31:16]), 1);
        check("stats_stall", 32'(stall_cnt), 1);
`endif
        repeat (4) @(negedge clk);
        #1;
        check("final_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trig_lookup_arbiter.md
Name: trig_lookup_arbiter

Overview:
- Shares one sin/cos ROM pair (11-bit entries, 360 deep, 2-cycle registered read) between several direction requesters, e.g. player and opponent motion update, instead of one ROM pair per kart.
- Arbitrates round-robin, issues at most one lookup per cycle, and tracks requester IDs through the ROM pipeline.
- Returns tagged cos/sin responses.
- Sits between the game motion logic and the shared cos/sin ROM instances.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ANGLE_W, 9, angle width in degrees.
- DATA_W, 11, ROM word width.
- ROM_LATENCY, 2, ROM address-to-data cycles; legal range 1..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_angle  in  NUM_REQ*ANGLE_W  packed angles; requester i occupies bits [i*ANGLE_W +: ANGLE_W].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- rom_addr  out  ANGLE_W  address to both shared ROMs.
- rom_cos  in  DATA_W  cos ROM data.
- rom_sin  in  DATA_W  sin ROM data.
- rsp_valid  out  NUM_REQ  one-hot response strobe, 1 cycle.
- rsp_cos  out  DATA_W  cos value for the responding requester.
- rsp_sin  out  DATA_W  sin value for the responding requester.
- busy  out  1  high while any lookup is in flight.

Behaviour:
- Reset: req_ready=0, rom_addr=0, rsp_valid=0, rsp_cos=0, rsp_sin=0, busy=0. The round-robin pointer resets to requester 0. The in-flight tag pipeline is cleared.
- Reset mid-operation discards all in-flight lookups. No rsp_valid fires for them after release.
- Arbitration:
  - req_ready is combinational from req_valid and the pointer. It is one-hot or zero; never more than one bit high.
  - Search starts at the pointer, ascending with wrap.
  - After a grant to requester i, the pointer moves to (i+1) mod NUM_REQ. With no grant, the pointer holds.
  - A requester must hold req_valid and req_angle stable until it is granted.
- Issue:
  - On the handshake edge, rom_addr is registered with the normalised angle, and the one-hot tag enters a ROM_LATENCY+1 deep shift register.
  - One grant per cycle gives full throughput: back-to-back grants with no bubbles.
- Angle normalisation: angle >= 360 maps to angle-360, so 360→0 and 511→151. Values 0..359 pass unchanged.
- Response:
  - rsp_valid equals the tag shift-register output.
  - rsp_cos/rsp_sin are registered from rom_cos/rom_sin when the tag is valid. They hold their last value otherwise.
  - Latency: handshake in cycle N gives rsp_valid in cycle N+ROM_LATENCY+1 (N+3 at default).
  - Responses return in grant order.
- busy = OR of all tag stages plus rom_addr-valid. It is registered and drops the cycle after the final rsp_valid.
- Simultaneous requests: all are served in round-robin order, one per cycle. No requester waits more than NUM_REQ-1 grants.
- A requester may re-request in the cycle after its grant. It is granted only if no other requester is pending ahead of it in round-robin order.

Optional Feature:
- Macro: TRIG_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt (NUM_REQ*16): per-requester saturating grant counters.
  - Adds output stall_cnt (16): counts cycles with req_valid != 0 but a pending requester not granted.
  - Both reset to 0, saturate at 16'hFFFF, and never wrap.
- When undefined: these ports and the counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid=01, angle0=90 in cycle 0 → req_ready=01 in cycle 0; rom_addr=90 in cycle 1; rsp_valid=01 in cycle 3 with rsp_cos/rsp_sin equal to ROM entry 90; busy low in cycle 4.
- Both requesters valid continuously, angle0=0, angle1=180 → grants alternate 01,10,01,10; rsp_valid alternates identically, 3 cycles later; no idle issue cycles.
- angle0=360, then 511 → rom_addr=0, then 151.
- req_valid=11 with pointer at 1 → requester 1 granted first, then requester 0.
- Assert rst 1 cycle after a grant → all outputs 0 immediately; no rsp_valid after release; the next request is granted to requester 0 first.
- With TRIG_ARB_STATS_EN, 3 grants to requester 0 and 1 contended cycle → grant_cnt[0]=3, stall_cnt=1. Forcing 70000 grants → grant_cnt holds at 65535.
